// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational Alu_RISC between two requesters.
// Round-robin grant, one-cycle ALU execution, per-requester response channel.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; ready given to the granted requester
// EXEC  | latched op/operands drive the ALU; result captured at the edge
// RESP  | result held for the owner until its rsp_ready handshake
module alu_share_arbiter #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int cnt_size  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [op_size-1:0]   req0_op_i,
    input  logic [word_size-1:0] req0_a_i,
    input  logic [word_size-1:0] req0_b_i,
    output logic                 rsp0_valid_o,
    input  logic                 rsp0_ready_i,

    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [op_size-1:0]   req1_op_i,
    input  logic [word_size-1:0] req1_a_i,
    input  logic [word_size-1:0] req1_b_i,
    output logic                 rsp1_valid_o,
    input  logic                 rsp1_ready_i,

    output logic [word_size-1:0] rsp_data_o,
    output logic                 rsp_zero_o,
    output logic                 rsp_err_o,

    output logic [op_size-1:0]   alu_sel_o,
    output logic [word_size-1:0] alu_data_1_o,
    output logic [word_size-1:0] alu_data_2_o,
    input  logic [word_size-1:0] alu_result_i,
    input  logic                 alu_zero_i,

    output logic [cnt_size-1:0]  op_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = op_size'(0);
    localparam logic [op_size-1:0] OP_ADD = op_size'(1);
    localparam logic [op_size-1:0] OP_SUB = op_size'(2);
    localparam logic [op_size-1:0] OP_AND = op_size'(3);
    localparam logic [op_size-1:0] OP_NOT = op_size'(4);
    localparam logic [op_size-1:0] OP_EQZ = op_size'(9);

    state_t                 state_q;
    logic                   last_grant_q;
    logic                   owner_q;
    logic [op_size-1:0]     alu_sel_q;
    logic [word_size-1:0]   alu_data_1_q;
    logic [word_size-1:0]   alu_data_2_q;
    logic [word_size-1:0]   rsp_data_q;
    logic                   rsp_zero_q;
    logic                   rsp_err_q;
    logic                   rsp0_valid_q;
    logic                   rsp1_valid_q;
    logic [cnt_size-1:0]    op_count_q;

    logic                   gnt0_d;
    logic                   gnt1_d;
    logic                   rsp_hs_d;

    function automatic logic op_legal(input logic [op_size-1:0] op);
        return (op == OP_NOP) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_NOT) || (op == OP_EQZ);
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (state_q == IDLE && !rst_i) begin
            gnt0_d = req0_valid_i && (!req1_valid_i || last_grant_q);
            gnt1_d = req1_valid_i && (!req0_valid_i || !last_grant_q);
        end
        rsp_hs_d = (rsp0_valid_q && rsp0_ready_i) || (rsp1_valid_q && rsp1_ready_i);
    end

    // Sequencer: accept, execute for one cycle, hold the response until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_sel_q    <= OP_NOP;
            alu_data_1_q <= '0;
            alu_data_2_q <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0_d || gnt1_d) begin
                        owner_q      <= gnt1_d;
                        alu_sel_q    <= gnt1_d ? req1_op_i : req0_op_i;
                        alu_data_1_q <= gnt1_d ? req1_a_i  : req0_a_i;
                        alu_data_2_q <= gnt1_d ? req1_b_i  : req0_b_i;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q   <= alu_result_i;
                    rsp_zero_q   <= alu_zero_i;
                    rsp_err_q    <= !op_legal(alu_sel_q);
                    // Return the ALU inputs to NOP/0 so its output stays quiet.
                    alu_sel_q    <= OP_NOP;
                    alu_data_1_q <= '0;
                    alu_data_2_q <= '0;
                    rsp0_valid_q <= !owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_hs_d) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        last_grant_q <= owner_q;
                        if (!(&op_count_q)) begin
                            op_count_q <= op_count_q + cnt_size'(1);
                        end
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready_o = gnt0_d;
    assign req1_ready_o = gnt1_d;
    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_err_o    = rsp_err_q;
    assign alu_sel_o    = alu_sel_q;
    assign alu_data_1_o = alu_data_1_q;
    assign alu_data_2_o = alu_data_2_q;
    assign op_count_o   = op_count_q;

endmodule
